// File: rtl/tinycpu_pkg.sv
// ---------------------------------------------------------------------------
// tinycpu_pkg
// Shared definitions for the TinyCPU instruction sequencer:
//   - seqState_t   : sequencer FSM states (IDLE / RUN / DONE)
//   - instrClass_t : coarse instruction class seen on the CPU `instr` bus
//   - opcode prefixes and the NOP encoding used while the CPU is parked
//   - decodeClass(): maps an instruction byte to its class
// No ports; imported by the sequencer top and available to benches.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package tinycpu_pkg;

   // Sequencer control states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seqState_t;

   // Instruction classes as far as the sequencer cares: only PRINT matters
   // for capture, LDI/ALU are distinguished for readability of the decoder.
   typedef enum logic [1:0] {
      CLASS_ALU   = 2'd0,
      CLASS_LDI   = 2'd1,
      CLASS_PRINT = 2'd2
   } instrClass_t;

   localparam logic [1:0] OP_LDI_PFX   = 2'b10;
   localparam logic [5:0] OP_PRINT_PFX = 6'b111100;
   localparam logic [7:0] INSTR_NOP    = 8'hF0;
   localparam logic [3:0] ALU_ADD      = 4'b0010;

   // LDI is checked first: its prefix can never overlap the PRINT prefix,
   // and everything that is neither falls through to the ALU class.
   function automatic instrClass_t decodeClass(input logic [7:0] instr);
      instrClass_t cls;
      cls = CLASS_ALU;
      if (instr[7:6] == OP_LDI_PFX) begin
         cls = CLASS_LDI;
      end else if (instr[7:2] == OP_PRINT_PFX) begin
         cls = CLASS_PRINT;
      end
      return cls;
   endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// ---------------------------------------------------------------------------
// instr_sequencer_if
// Bundles the host-side program/control signals and the TinyCPU-side
// instruction/result signals of the instruction sequencer.
//   Host -> sequencer : prog_we, prog_addr, prog_data, start, prog_len
//   Sequencer -> host : out_data, out_valid, busy, done
//   Sequencer -> CPU  : instr, pc
//   CPU -> sequencer  : cpu_res
// Modports:
//   slave  - the sequencer itself
//   master - the environment (host plus CPU) around the sequencer
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface instr_sequencer_if #(
   parameter int AW = 4
);

   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [7:0]    prog_data;
   logic          start;
   logic [AW:0]   prog_len;

   logic [7:0]    instr;
   logic [7:0]    cpu_res;

   logic [7:0]    out_data;
   logic          out_valid;
   logic          busy;
   logic          done;
   logic [AW-1:0] pc;

   modport slave (
      input  prog_we,
      input  prog_addr,
      input  prog_data,
      input  start,
      input  prog_len,
      input  cpu_res,
      output instr,
      output out_data,
      output out_valid,
      output busy,
      output done,
      output pc
   );

   modport master (
      output prog_we,
      output prog_addr,
      output prog_data,
      output start,
      output prog_len,
      output cpu_res,
      input  instr,
      input  out_data,
      input  out_valid,
      input  busy,
      input  done,
      input  pc
   );

endinterface

// File: rtl/instr_sequencer_prog_mem.sv
// ---------------------------------------------------------------------------
// prog_mem
// Small program store for the instruction sequencer: DEPTH x 8 bits,
// synchronous write, asynchronous (combinational) read so the addressed
// instruction reaches the CPU in the same cycle the pc changes.
// Contents are intentionally not reset.
// Ports:
//   clk    in  1   write clock
//   we     in  1   write enable
//   waddr  in  AW  write address
//   wdata  in  8   write data
//   raddr  in  AW  read address
//   rdata  out 8   read data (combinational from raddr)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module prog_mem #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem_q [DEPTH];

   // Plain write port; no reset so the array maps onto distributed RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
// Issuing end of TinyCPU's instruction interface. A host fills the program
// store while the block is idle, then pulses start. Each stored instruction
// is driven on `instr` for HOLD_CYCLES cycles so the CPU register file has
// settled before the next one; for PRINT instructions the CPU's combinational
// `res` is captured on the last hold cycle and handed to the host with a
// one-cycle out_valid pulse. A single-cycle DONE state closes every run.
// Parameters:
//   DEPTH        program store entries (power of two)
//   AW           log2(DEPTH)
//   HOLD_CYCLES  cycles each instruction stays on `instr` (>= 1)
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous active-low reset
//   bus    slave modport of instr_sequencer_if:
//          prog_we/prog_addr/prog_data  program writes (IDLE only)
//          start/prog_len               launch a run (IDLE only)
//          instr/pc                     instruction and its index to the CPU
//          cpu_res                      CPU result, combinational from instr
//          out_data/out_valid           captured PRINT result and its pulse
//          busy/done                    run in progress / run finished pulse
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module instr_sequencer
   import tinycpu_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int AW          = 4,
   parameter int HOLD_CYCLES = 2
) (
   input logic              clk,
   input logic              rst_n,
   instr_sequencer_if.slave bus
);

   // A counter of at least one bit keeps HOLD_CYCLES=1 legal; in that case
   // it simply sits at zero and every RUN cycle is a final hold cycle.
   localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [AW:0]   LEN_MAX   = DEPTH[AW:0];

   seqState_t     state_q,    state_d;
   logic [AW-1:0] pc_q,       pc_d;
   logic [HW-1:0] holdCnt_q,  holdCnt_d;
   logic [AW:0]   len_q,      len_d;
   logic [7:0]    outData_q,  outData_d;
   logic          outValid_q, outValid_d;

   logic          memWe;
   logic [7:0]    memRdata;
   logic          lastHold;
   logic          lastInstr;
   logic          isPrint;

   prog_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) uProgMem (
      .clk   (clk),
      .we    (memWe),
      .waddr (bus.prog_addr),
      .wdata (bus.prog_data),
      .raddr (pc_q),
      .rdata (memRdata)
   );

   // len_q is never zero in RUN (a zero-length start goes straight to DONE),
   // so len_q - 1 cannot underflow where lastInstr is actually used.
   assign lastHold  = (holdCnt_q == HOLD_LAST);
   assign lastInstr = ({1'b0, pc_q} == (len_q - 1'b1));
   assign isPrint   = (decodeClass(memRdata) == CLASS_PRINT);

   assign bus.pc        = pc_q;
   assign bus.out_data  = outData_q;
   assign bus.out_valid = outValid_q;

   // State register. Reset clears every control and output register but
   // leaves the program store alone, so a host can rerun without reloading.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_q       <= '0;
         holdCnt_q  <= '0;
         len_q      <= '0;
         outData_q  <= 8'h00;
         outValid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         holdCnt_q  <= holdCnt_d;
         len_q      <= len_d;
         outData_q  <= outData_d;
         outValid_q <= outValid_d;
      end
   end

   // Next-state and output logic. Outside RUN the CPU always sees NOP,
   // which is a PRINT with no side effect and is never captured here.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      holdCnt_d  = holdCnt_q;
      len_d      = len_q;
      outData_d  = outData_q;
      outValid_d = 1'b0;
      memWe      = 1'b0;
      bus.instr  = INSTR_NOP;
      bus.busy   = 1'b0;
      bus.done   = 1'b0;

      case (state_q)
         IDLE: begin
            // A write coinciding with start lands at this edge, and the
            // first instruction is only read next cycle, so it sees the data.
            memWe = bus.prog_we;
            if (bus.start) begin
               len_d     = (bus.prog_len > LEN_MAX) ? LEN_MAX : bus.prog_len;
               pc_d      = '0;
               holdCnt_d = '0;
               state_d   = (bus.prog_len == '0) ? DONE : RUN;
            end
         end

         RUN: begin
            bus.instr = memRdata;
            bus.busy  = 1'b1;
            if (lastHold) begin
               holdCnt_d = '0;
               if (isPrint) begin
                  outData_d  = bus.cpu_res;
                  outValid_d = 1'b1;
               end
               if (lastInstr) begin
                  pc_d    = '0;
                  state_d = DONE;
               end else begin
                  pc_d = pc_q + 1'b1;
               end
            end else begin
               holdCnt_d = holdCnt_q + 1'b1;
            end
         end

         DONE: begin
            bus.done = 1'b1;
            pc_d     = '0;
            state_d  = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
// Drives two sequencers (HOLD_CYCLES=2 and HOLD_CYCLES=1), each feeding a
// small behavioural TinyCPU stub, and compares every cycle of every run
// against a reference computed from the program image: which instruction
// should be on the bus, when busy/done occur, and which PRINT values
// should be reported in which cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_instr_sequencer;
   import tinycpu_pkg::*;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int LW    = AW + 1;

   typedef logic [3:0][7:0] regFile_t;

   typedef struct packed {
      logic [7:0]    instr;
      logic [7:0]    outData;
      logic          outValid;
      logic          busy;
      logic          done;
      logic [AW-1:0] pc;
   } dutOut_t;

   logic clk      = 1'b0;
   logic rstN     = 1'b0;
   logic cpuClear = 1'b1;

   int         checkCount = 0;
   int         errorCount = 0;
   int         validSeen;
   logic [7:0] lastSeenData;
   logic [7:0] progImg [DEPTH];

   regFile_t regsA;
   regFile_t regsB;

   always #5 clk = ~clk;

   instr_sequencer_if #(.AW(AW)) busA ();
   instr_sequencer_if #(.AW(AW)) busB ();

   instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .HOLD_CYCLES(2)) dutA (
      .clk   (clk),
      .rst_n (rstN),
      .bus   (busA)
   );

   instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .HOLD_CYCLES(1)) dutB (
      .clk   (clk),
      .rst_n (rstN),
      .bus   (busB)
   );

   // TinyCPU behaviour: LDI = 10 rd[5:4] imm[3:0] (sign-extended),
   // PRINT = 111100 rs[1:0], ALU = op[7:4] ra[3:2] rb[1:0] writing r2.
   function automatic regFile_t applyInstr(input regFile_t r, input logic [7:0] i);
      regFile_t   n;
      logic [7:0] a;
      logic [7:0] b;
      n = r;
      a = r[i[3:2]];
      b = r[i[1:0]];
      if (i[7:6] == OP_LDI_PFX) begin
         n[i[5:4]] = {{4{i[3]}}, i[3:0]};
      end else if (i[7:2] != OP_PRINT_PFX) begin
         case (i[7:4])
            ALU_ADD: n[2] = a + b;
            4'b0011: n[2] = a - b;
            default: n[2] = a ^ b;
         endcase
      end
      return n;
   endfunction

   function automatic logic [7:0] cpuRes(input regFile_t r, input logic [7:0] i);
      logic [7:0] res;
      if (i[7:2] == OP_PRINT_PFX) res = r[i[1:0]];
      else                        res = ~r[i[1:0]];
      return res;
   endfunction

   // CPU stubs: registers update on every edge with whatever is on instr.
   always @(posedge clk) begin
      if (cpuClear) begin
         regsA <= '0;
         regsB <= '0;
      end else begin
         regsA <= applyInstr(regsA, busA.instr);
         regsB <= applyInstr(regsB, busB.instr);
      end
   end

   assign busA.cpu_res = cpuRes(regsA, busA.instr);
   assign busB.cpu_res = cpuRes(regsB, busB.instr);

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic driveHost(input int sel, input logic we, input logic [AW-1:0] addr,
                            input logic [7:0] data, input logic st, input logic [LW-1:0] len);
      if (sel == 0) begin
         busA.prog_we   = we;
         busA.prog_addr = addr;
         busA.prog_data = data;
         busA.start     = st;
         busA.prog_len  = len;
      end else begin
         busB.prog_we   = we;
         busB.prog_addr = addr;
         busB.prog_data = data;
         busB.start     = st;
         busB.prog_len  = len;
      end
   endtask

   function automatic dutOut_t sampleOut(input int sel);
      dutOut_t o;
      if (sel == 0) begin
         o.instr = busA.instr; o.outData = busA.out_data; o.outValid = busA.out_valid;
         o.busy  = busA.busy;  o.done    = busA.done;     o.pc       = busA.pc;
      end else begin
         o.instr = busB.instr; o.outData = busB.out_data; o.outValid = busB.out_valid;
         o.busy  = busB.busy;  o.done    = busB.done;     o.pc       = busB.pc;
      end
      return o;
   endfunction

   function automatic logic [7:0] randInstr();
      logic [7:0] v;
      case ($urandom_range(0, 2))
         0:       v = {OP_PRINT_PFX, 2'($urandom_range(0, 3))};
         1:       v = {OP_LDI_PFX, 6'($urandom)};
         default: v = 8'($urandom);
      endcase
      return v;
   endfunction

   task automatic setImage(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input int cnt);
      for (int i = 0; i < DEPTH; i++) progImg[i] = 8'h00;
      progImg[0] = b0;
      if (cnt > 1) progImg[1] = b1;
      if (cnt > 2) progImg[2] = b2;
      if (cnt > 3) progImg[3] = b3;
   endtask

   // One complete run: optional load, start, then a per-cycle comparison
   // with the expected bus contents and PRINT reports derived from progImg.
   task automatic applyStimulus(input int sel, input int lenReq, input bit doLoad,
                                input bit mergeStart, input bit disturb);
      int         hold;
      int         n;
      int         runCycles;
      bit         busyExp;
      regFile_t   model;
      bit         expValid [40];
      logic [7:0] expVal [40];
      dutOut_t    o;

      hold      = (sel == 0) ? 2 : 1;
      n         = (lenReq > DEPTH) ? DEPTH : lenReq;
      runCycles = n * hold;

      for (int i = 0; i < 40; i++) begin
         expValid[i] = 1'b0;
         expVal[i]   = 8'h00;
      end
      model = '0;
      for (int k = 0; k < n; k++) begin
         if (progImg[k][7:2] == OP_PRINT_PFX) begin
            expValid[(k + 1) * hold + 1] = 1'b1;
            expVal[(k + 1) * hold + 1]   = model[progImg[k][1:0]];
         end else begin
            for (int h = 0; h < hold; h++) model = applyInstr(model, progImg[k]);
         end
      end

      @(negedge clk);
      cpuClear = 1'b1;
      @(negedge clk);
      cpuClear = 1'b0;

      if (doLoad) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (!(mergeStart && i == DEPTH - 1)) begin
               driveHost(sel, 1'b1, AW'(i), progImg[i], 1'b0, '0);
               @(negedge clk);
            end
         end
      end

      if (doLoad && mergeStart)
         driveHost(sel, 1'b1, AW'(DEPTH - 1), progImg[DEPTH - 1], 1'b1, LW'(lenReq));
      else
         driveHost(sel, 1'b0, '0, 8'h00, 1'b1, LW'(lenReq));

      validSeen = 0;
      for (int c = 1; c <= runCycles + 2; c++) begin
         @(negedge clk);
         o = sampleOut(sel);
         if (c == 1) driveHost(sel, 1'b0, '0, 8'h00, 1'b0, '0);
         if (disturb && c == 2) driveHost(sel, 1'b1, AW'(3), 8'h00, 1'b1, LW'(1));
         if (disturb && c == 3) driveHost(sel, 1'b0, '0, 8'h00, 1'b0, '0);

         busyExp = (c <= runCycles);
         checkOutput("busy", 32'(o.busy), 32'(busyExp));
         checkOutput("done", 32'(o.done), 32'(c == runCycles + 1));
         checkOutput("instr", 32'(o.instr), busyExp ? 32'(progImg[(c - 1) / hold]) : 32'(INSTR_NOP));
         checkOutput("pc", 32'(o.pc), busyExp ? 32'((c - 1) / hold) : 32'(0));
         checkOutput("out_valid", 32'(o.outValid), 32'(expValid[c]));
         if (expValid[c]) begin
            checkOutput("out_data", 32'(o.outData), 32'(expVal[c]));
            lastSeenData = o.outData;
            validSeen++;
         end
      end
   endtask

   // Watchdog in case the clock or a task never returns.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      dutOut_t o;

      driveHost(0, 1'b0, '0, 8'h00, 1'b0, '0);
      driveHost(1, 1'b0, '0, 8'h00, 1'b0, '0);
      rstN = 1'b0;
      repeat (3) @(negedge clk);

      for (int s = 0; s < 2; s++) begin
         o = sampleOut(s);
         checkOutput("reset instr", 32'(o.instr), 32'(8'hF0));
         checkOutput("reset out_data", 32'(o.outData), 32'(0));
         checkOutput("reset out_valid", 32'(o.outValid), 32'(0));
         checkOutput("reset busy", 32'(o.busy), 32'(0));
         checkOutput("reset done", 32'(o.done), 32'(0));
         checkOutput("reset pc", 32'(o.pc), 32'(0));
      end
      rstN     = 1'b1;
      cpuClear = 1'b0;

      $display("[TB] basic add-and-print program");
      setImage(8'h85, 8'h93, 8'h21, 8'hF2, 4);
      applyStimulus(0, 4, 1'b1, 1'b0, 1'b0);
      checkOutput("t1 prints", 32'(validSeen), 32'(1));
      checkOutput("t1 value", 32'(lastSeenData), 32'(8'h08));

      $display("[TB] reset in the middle of a run");
      @(negedge clk);
      driveHost(0, 1'b0, '0, 8'h00, 1'b1, LW'(4));
      @(negedge clk);
      driveHost(0, 1'b0, '0, 8'h00, 1'b0, '0);
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b0;
      @(negedge clk);
      rstN = 1'b1;
      for (int c = 0; c < 6; c++) begin
         o = sampleOut(0);
         checkOutput("abort instr", 32'(o.instr), 32'(8'hF0));
         checkOutput("abort busy", 32'(o.busy), 32'(0));
         checkOutput("abort out_valid", 32'(o.outValid), 32'(0));
         checkOutput("abort done", 32'(o.done), 32'(0));
         @(negedge clk);
      end
      applyStimulus(0, 4, 1'b0, 1'b0, 1'b0);
      checkOutput("restart value", 32'(lastSeenData), 32'(8'h08));

      $display("[TB] writes and start ignored while running");
      applyStimulus(0, 4, 1'b0, 1'b0, 1'b1);
      applyStimulus(0, 4, 1'b0, 1'b0, 1'b0);
      checkOutput("readback value", 32'(lastSeenData), 32'(8'h08));

      $display("[TB] negative immediate");
      setImage(8'hAF, 8'hF2, 8'h00, 8'h00, 2);
      applyStimulus(0, 2, 1'b1, 1'b0, 1'b0);
      checkOutput("t2 value", 32'(lastSeenData), 32'(8'hFF));

      $display("[TB] zero-length run");
      applyStimulus(0, 0, 1'b0, 1'b0, 1'b0);
      checkOutput("t3 prints", 32'(validSeen), 32'(0));

      $display("[TB] single-cycle hold, back-to-back prints");
      setImage(8'h87, 8'hF0, 8'hF0, 8'h00, 3);
      applyStimulus(1, 3, 1'b1, 1'b0, 1'b0);
      checkOutput("t6 prints", 32'(validSeen), 32'(2));
      checkOutput("t6 value", 32'(lastSeenData), 32'(8'h07));

      $display("[TB] length clamp and write merged with start");
      for (int i = 0; i < DEPTH; i++) progImg[i] = randInstr();
      progImg[DEPTH - 1] = 8'hF1;
      applyStimulus(0, 20, 1'b1, 1'b1, 1'b0);
      applyStimulus(1, 16, 1'b1, 1'b1, 1'b0);

      $display("[TB] randomized programs");
      for (int r = 0; r < 24; r++) begin
         for (int i = 0; i < DEPTH; i++) progImg[i] = randInstr();
         applyStimulus(r % 2, $urandom_range(0, 20), 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Drives the 8-bit `instr` input of TinyCPU from a small on-chip program store; it is the issuing end of the CPU's instruction interface.
- A host loads up to DEPTH instruction bytes, then pulses `start`.
- The block issues each instruction for HOLD_CYCLES cycles, so register-file writeback settles, and captures the CPU's `res` for every print instruction.
- Captured values are presented to the host with a valid pulse.

Parameters:
- DEPTH, 16, program store entries; a power of two.
- AW, 4, address and length width (log2 DEPTH).
- HOLD_CYCLES, 2, cycles each instruction is held on `instr`; must be ≥1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset.
- prog_we  input  1  program write strobe; honoured only in IDLE.
- prog_addr  input  AW  program write address.
- prog_data  input  8  instruction byte to store.
- start  input  1  begin execution; honoured only in IDLE.
- prog_len  input  AW+1  instruction count, sampled with `start`; 0..DEPTH.
- instr  output  8  instruction to TinyCPU.
- cpu_res  input  8  TinyCPU `res`; combinational from `instr`.
- out_data  output  8  last captured print result.
- out_valid  output  1  one-cycle pulse when `out_data` updates.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse on run completion.
- pc  output  AW  index of the instruction on `instr`.

Behaviour:
- Reset (rst_n=0 at an edge) gives state=IDLE, instr=8'hF0 (NOP), out_data=0, out_valid=0, busy=0, done=0, pc=0, hold counter=0.
  - Program store contents are not reset.
  - Reset mid-run aborts the run, with no done or out_valid pulse.
- Instruction classes, decoded from bits [7:6] and [7:2]:
  - LDI: instr[7:6]=10.
  - PRINT: instr[7:2]=111100, which has no register write.
  - ALU: all other encodings.
- NOP is 8'hF0 (PRINT r0). It has no CPU side effect and is never captured while not in RUN.
- IDLE state:
  - `instr` = NOP.
  - prog_we=1 writes prog_data to mem[prog_addr] at the edge.
  - start=1 latches prog_len into len_r, sets pc=0 and hold counter=0.
  - Next state is RUN if prog_len≠0, else DONE.
  - If start and prog_we occur together, the write is performed first and the run begins next cycle with the updated memory.
- RUN state:
  - `instr` = mem[pc] (asynchronous read); busy=1.
  - The hold counter increments each cycle.
  - Final hold cycle (counter = HOLD_CYCLES-1):
    - If instr is PRINT, cpu_res is registered into out_data and out_valid=1 for the next cycle.
    - The counter clears.
    - If pc = len_r-1, next state is DONE; otherwise pc increments.
  - prog_we and start are ignored in RUN.
- DONE state: lasts one cycle with done=1, instr=NOP, pc=0; next state is IDLE.
  - An out_valid pulse from the last PRINT coincides with the done cycle.
- Latency:
  - First instruction appears the cycle after `start`.
  - A run takes prog_len×HOLD_CYCLES cycles in RUN, plus 1 DONE cycle.
- Edge cases:
  - prog_len > DEPTH is clamped to DEPTH.
  - pc never wraps within a run.
  - Back-to-back PRINTs produce back-to-back out_valid pulses when HOLD_CYCLES=1.

Decomposition:
- Shared package `tinycpu_pkg`:
  - state enum IDLE/RUN/DONE;
  - constants OP_LDI_PFX=2'b10, OP_PRINT_PFX=6'b111100, INSTR_NOP=8'hF0, ALU_ADD=4'b0010.
- One sub-module `prog_mem`: DEPTH×8, synchronous write, asynchronous read.
- The FSM, hold counter and capture logic stay in the top.

Test Plan:
1. Load [0x85, 0x93, 0x21, 0xF2], prog_len=4, start (bench wired to TinyCPU, HOLD=2). Expect one out_valid with out_data=8'h08; done pulse exactly 9 cycles after start; busy high 8 cycles.
2. Load [0xAF, 0xF2], prog_len=2, start. Expect out_data=8'hFF (sign-extended −1); done at cycle 5.
3. prog_len=0, start. Expect no busy; done pulse the cycle after start; instr stays 8'hF0.
4. Mid-run (cycle 3 of test 1), assert rst_n=0 for one cycle. Expect instr=8'hF0, busy=0, no out_valid/done. A restart then reproduces test 1 exactly.
5. During RUN, pulse prog_we to addr 3 with 0x00, and pulse start. Expect both ignored: memory is unchanged (readback run prints 8'h08) and no run restart.
6. HOLD_CYCLES=1, program [0x87, 0xF0, 0xF0], prog_len=3. Expect two consecutive out_valid pulses with out_data=8'h07; done coincides with the second pulse.
